// File: rtl/alu74181_nibble_seq_if.sv
// Start/busy/done handshake and operand/result bus for the nibble-serial 74181 sequencer.
// The master drives the request, the slave (sequencer) returns status and result.
interface alu74181_nibble_seq_if #(
  parameter int unsigned N_NIBBLES = 4
) ();
  localparam int unsigned W = 4 * N_NIBBLES;

  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, zero
  );
endinterface

// File: rtl/alu74181_nibble_seq.sv
// 74181 4-bit ALU slice (active-high data, active-low carries) and a controller that runs it
// one nibble per clock, LSB first, with the slice carry registered between nibbles.
module alu74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4,
  output logic       g,
  output logic       p,
  output logic       aeqb
);
  logic [3:0] x;
  logic [3:0] y;
  logic [4:0] c;
  logic       gen;

  always_comb begin
    // x is the inverted per-bit propagate, y the inverted per-bit generate
    x    = ~(a | (b & {4{s[0]}}) | (~b & {4{s[1]}}));
    y    = ~((a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}}));
    c    = '0;
    c[0] = ~cn;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = ~y[i] | (~x[i] & c[i]);
    end
    f    = ~(x ^ y) ^ ({4{~m}} & ~c[3:0]);
    cn4  = ~c[4];
    gen  = ~y[3] | (~x[3] & ~y[2]) | (~x[3] & ~x[2] & ~y[1]) | (~x[3] & ~x[2] & ~x[1] & ~y[0]);
    g    = ~gen;
    p    = ~(&(~x));
    aeqb = &f;
  end
endmodule

module alu74181_nibble_seq #(
  parameter int unsigned N_NIBBLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  alu74181_nibble_seq_if.slave bus
);
  localparam int unsigned W    = 4 * N_NIBBLES;
  localparam int unsigned IdxW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  typedef struct packed {
    logic [3:0] s;
    logic       m;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [2:0] opc);
    ctrl_t ctl;
    case (opc)
      3'b000:  ctl = '{s: 4'b1001, m: 1'b0};
      3'b001:  ctl = '{s: 4'b0110, m: 1'b0};
      3'b010:  ctl = '{s: 4'b1011, m: 1'b1};
      3'b011:  ctl = '{s: 4'b1110, m: 1'b1};
      3'b100:  ctl = '{s: 4'b0110, m: 1'b1};
      3'b101:  ctl = '{s: 4'b0000, m: 1'b1};
      3'b110:  ctl = '{s: 4'b0000, m: 1'b0};
      default: ctl = '{s: 4'b1111, m: 1'b0};
    endcase
    return ctl;
  endfunction

  // Initial carry-in, active low: SUB and INC inject a +1, everything else starts clear
  function automatic logic start_cn(input logic [2:0] opc);
    return !(opc == 3'b001 || opc == 3'b110);
  endfunction

  state_e          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [2:0]      op_q;
  logic [IdxW-1:0] idx_q;
  logic            cn_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    result_q;
  logic            carry_out_q;
  logic            zero_q;

  ctrl_t        run_ctrl;
  logic [3:0]   slice_a;
  logic [3:0]   slice_b;
  logic [3:0]   slice_f;
  logic         slice_cn4;
  logic         unused_g;
  logic         unused_p;
  logic         unused_aeqb;
  logic [W-1:0] result_nxt;

  assign run_ctrl = decode(op_q);
  assign slice_a  = a_q[{idx_q, 2'b00} +: 4];
  assign slice_b  = b_q[{idx_q, 2'b00} +: 4];

  alu74181 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .s    (run_ctrl.s),
    .m    (run_ctrl.m),
    .cn   (cn_q),
    .f    (slice_f),
    .cn4  (slice_cn4),
    .g    (unused_g),
    .p    (unused_p),
    .aeqb (unused_aeqb)
  );

  always_comb begin
    result_nxt                         = result_q;
    result_nxt[{idx_q, 2'b00} +: 4]    = slice_f;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      idx_q       <= '0;
      cn_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      carry_out_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          result_q <= result_nxt;
          cn_q     <= slice_cn4;
          if (idx_q == LastIdx) begin
            state_q     <= StDone;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            carry_out_q <= run_ctrl.m ? 1'b0 : ~slice_cn4;
            zero_q      <= (result_nxt == '0);
          end else begin
            idx_q <= idx_q + IdxW'(1);
          end
        end
        default: begin
          // Idle and Done both accept a new request; result and flags hold until then
          done_q <= 1'b0;
          if (bus.start) begin
            state_q <= StRun;
            a_q     <= bus.a;
            b_q     <= bus.b;
            op_q    <= bus.op;
            idx_q   <= '0;
            cn_q    <= start_cn(bus.op);
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_out_q;
  assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu74181_nibble_seq.sv
// Bench for alu74181_nibble_seq: vector table plus handshake and mid-run reset sequences,
// with a done-triggered scoreboard comparing result/carry_out/zero.
module tb_alu74181_nibble_seq;
  localparam int unsigned NN = 4;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    exp_t        e;
  } vec_t;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  exp_t sb_q[$];
  exp_t mon_e;
  vec_t vecs[14];

  alu74181_nibble_seq_if #(.N_NIBBLES(NN)) bus ();

  alu74181_nibble_seq #(.N_NIBBLES(NN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] r, input logic c, input logic z);
    exp_t e;
    e.res  = r;
    e.cout = c;
    e.zero = z;
    return e;
  endfunction

  // Plain-arithmetic reference used for the back-to-back sequence
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    exp_t        e;
    case (op)
      3'd0:    s = {1'b0, a} + {1'b0, b};
      3'd1:    s = {1'b0, a} + {1'b0, ~b} + 17'd1;
      3'd2:    s = {1'b0, a & b};
      3'd3:    s = {1'b0, a | b};
      3'd4:    s = {1'b0, a ^ b};
      3'd5:    s = {1'b0, ~a};
      3'd6:    s = {1'b0, a} + 17'd1;
      default: s = {1'b0, a} + 17'h0FFFF;
    endcase
    e.res  = s[15:0];
    e.cout = (op == 3'd0 || op == 3'd1 || op == 3'd6 || op == 3'd7) ? s[16] : 1'b0;
    e.zero = (s[15:0] == 16'h0);
    return e;
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        check(1'b0, "unexpected_done", {15'd0, bus.result, bus.carry_out}, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check({bus.result, bus.carry_out, bus.zero} === mon_e, "done_result",
              {14'd0, bus.result, bus.carry_out, bus.zero}, {14'd0, mon_e});
      end
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                       input exp_t e);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb_q.push_back(e);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) bus.start = 1'b0;
      check(bus.busy === 1'b1 && bus.done === 1'b0, "busy_window",
            {30'd0, bus.busy, bus.done}, 32'h2);
    end
    @(negedge clk);
    check(bus.done === 1'b1 && bus.busy === 1'b0, "done_latency",
          {30'd0, bus.busy, bus.done}, 32'h1);
  endtask

  initial begin
    int n_done;
    int cyc;
    int last_cyc;
    exp_t e;

    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 16'h0;
    bus.b     = 16'h0;

    vecs[0]  = '{op: 3'd0, a: 16'h1234, b: 16'h0FFF, e: mk(16'h2233, 1'b0, 1'b0)};
    vecs[1]  = '{op: 3'd0, a: 16'hFFFF, b: 16'h0001, e: mk(16'h0000, 1'b1, 1'b1)};
    vecs[2]  = '{op: 3'd6, a: 16'hFFFF, b: 16'h0000, e: mk(16'h0000, 1'b1, 1'b1)};
    vecs[3]  = '{op: 3'd1, a: 16'h0003, b: 16'h0004, e: mk(16'hFFFF, 1'b0, 1'b0)};
    vecs[4]  = '{op: 3'd1, a: 16'h5000, b: 16'h1000, e: mk(16'h4000, 1'b1, 1'b0)};
    vecs[5]  = '{op: 3'd7, a: 16'h0000, b: 16'h0000, e: mk(16'hFFFF, 1'b0, 1'b0)};
    vecs[6]  = '{op: 3'd2, a: 16'hF0F0, b: 16'h3C3C, e: mk(16'h3030, 1'b0, 1'b0)};
    vecs[7]  = '{op: 3'd3, a: 16'hF0F0, b: 16'h3C3C, e: mk(16'hFCFC, 1'b0, 1'b0)};
    vecs[8]  = '{op: 3'd4, a: 16'hF0F0, b: 16'h3C3C, e: mk(16'hCCCC, 1'b0, 1'b0)};
    vecs[9]  = '{op: 3'd5, a: 16'h00FF, b: 16'h3C3C, e: mk(16'hFF00, 1'b0, 1'b0)};
    vecs[10] = '{op: 3'd1, a: 16'h1234, b: 16'h1234, e: mk(16'h0000, 1'b1, 1'b1)};
    vecs[11] = '{op: 3'd4, a: 16'hA5A5, b: 16'hA5A5, e: mk(16'h0000, 1'b0, 1'b1)};
    vecs[12] = '{op: 3'd7, a: 16'h0001, b: 16'h0000, e: mk(16'h0000, 1'b1, 1'b1)};
    vecs[13] = '{op: 3'd0, a: 16'h8000, b: 16'h8000, e: mk(16'h0000, 1'b1, 1'b1)};

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check({bus.busy, bus.done, bus.carry_out, bus.zero} === 4'b0000, "reset_flags",
          {28'd0, bus.busy, bus.done, bus.carry_out, bus.zero}, 32'd0);
    check(bus.result === 16'h0, "reset_result", {16'd0, bus.result}, 32'd0);

    foreach (vecs[i]) do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);

    // start during RUN with other operands must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 16'h0102; bus.b = 16'h0304;
    sb_q.push_back(mk(16'h0406, 1'b0, 1'b0));
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd1; bus.a = 16'hFFFF; bus.b = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check(bus.done === 1'b1, "ignored_start_done", {31'd0, bus.done}, 32'd1);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check(n_done == 0, "ignored_start_no_extra", n_done, 32'd0);

    // start held high: back-to-back ops, one done every N+1 cycles
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 16'h7FFF; bus.b = 16'h0001;
    sb_q.push_back(model(3'd0, 16'h7FFF, 16'h0001));
    n_done   = 0;
    cyc      = 0;
    last_cyc = 0;
    while (n_done < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        check(cyc - last_cyc == 5, "b2b_period", cyc - last_cyc, 32'd5);
        last_cyc = cyc;
        n_done++;
        if (n_done == 1) begin
          bus.op = 3'd1; bus.a = 16'h0010; bus.b = 16'h0020;
          sb_q.push_back(model(3'd1, 16'h0010, 16'h0020));
        end else if (n_done == 2) begin
          bus.op = 3'd3; bus.a = 16'h1200; bus.b = 16'h0034;
          sb_q.push_back(model(3'd3, 16'h1200, 16'h0034));
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check(n_done == 3, "b2b_count", n_done, 32'd3);

    // reset while the third nibble is in flight
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.a = 16'h1111; bus.b = 16'h1111;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check({bus.busy, bus.done, bus.carry_out, bus.zero} === 4'b0000, "midrun_reset_flags",
          {28'd0, bus.busy, bus.done, bus.carry_out, bus.zero}, 32'd0);
    check(bus.result === 16'h0, "midrun_reset_result", {16'd0, bus.result}, 32'd0);
    n_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check(n_done == 0, "midrun_reset_no_done", n_done, 32'd0);
    e = mk(16'h579B, 1'b0, 1'b0);
    do_op(3'd0, 16'h1234, 16'h4567, e);

    repeat (3) @(negedge clk);
    check(sb_q.size() == 0, "scoreboard_drained", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu74181_nibble_seq.md
Name: alu74181_nibble_seq

Overview:
Multi-cycle controller that computes W-bit arithmetic/logic results using a single internally instantiated alu74181 4-bit slice, one nibble per clock, LSB nibble first. The Cn4-to-Cn carry is registered between nibbles. It decodes a 3-bit opcode into the slice's S/M/Cn controls and provides a start/busy/done handshake to the surrounding datapath.

Parameters:
N_NIBBLES, 4, number of 4-bit slices processed per operation; W = 4*N_NIBBLES (min 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
op  in  3  opcode, latched on accept
a  in  W  operand A, latched on accept
b  in  W  operand B, latched on accept
busy  out  1  operation in progress
done  out  1  one-cycle pulse: result/flags valid
result  out  W  result word, held until next accept
carry_out  out  1  active-high carry / no-borrow of final nibble
zero  out  1  result == 0

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at a rising edge): state=IDLE, busy=0, done=0, result=0, carry_out=0, zero=0, nibble index=0, carry register=1 (no carry, active-low). Reset overrides all activity, including mid-RUN; any partial result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE or DONE with start=1: latch a, b, op; set idx=0; load carry register with the op's initial Cn; go to RUN.
  - RUN: drive the slice with A=a_q[4idx+3:4idx], B=b_q[...], S/M from op, Cn=carry register. At each edge, write F into result[4idx+3:4idx] and capture Cn4 into the carry register. If idx=N_NIBBLES-1, go to DONE; otherwise idx+1.
  - DONE: done=1 for exactly this cycle. With no start, go to IDLE next edge.
- busy=1 exactly while in RUN. start in RUN is ignored.
- Latency: start accepted at edge t; done is high in the cycle after edge t+N_NIBBLES (4 cycles for the default).
- Opcode decode (active-high data convention, Cn active-low):
  - 000 ADD: S=1001 M=0 Cn0=1
  - 001 SUB (A-B): S=0110 M=0 Cn0=0
  - 010 AND: S=1011 M=1
  - 011 OR: S=1110 M=1
  - 100 XOR: S=0110 M=1
  - 101 NOTA: S=0000 M=1
  - 110 INC (A+1): S=0000 M=0 Cn0=0
  - 111 DEC (A-1): S=1111 M=0 Cn0=1
  - Logic ops (M=1) drive Cn=1.
- Carry chain: nibble k uses Cn = Cn4 of nibble k-1; nibble 0 uses Cn0.
- Flags, updated at the final RUN edge:
  - carry_out = ~Cn4 of the last nibble for arithmetic ops; 0 for logic ops.
  - For SUB/DEC, carry_out=1 means no borrow.
  - zero = (final result == 0).
- result is updated nibble-by-nibble during RUN, so intermediate values are visible. Consumers use result only when done=1 or after done.
- G, P and AeqB from the slice are unused.
- Back-to-back operation: start=1 in the DONE cycle is accepted, giving one done pulse every N_NIBBLES+1 cycles.

Test Plan:
1. ADD a=0x1234 b=0x0FFF -> done exactly 4 cycles after accept; result=0x2233, carry_out=0, zero=0; busy high for 4 cycles.
2. ADD a=0xFFFF b=0x0001 -> result=0x0000, carry_out=1, zero=1. INC a=0xFFFF -> same result and flags.
3. SUB a=0x0003 b=0x0004 -> result=0xFFFF, carry_out=0 (borrow). SUB a=0x5000 b=0x1000 -> result=0x4000, carry_out=1. DEC a=0x0000 -> result=0xFFFF, carry_out=0.
4. Logic with a=0xF0F0 b=0x3C3C: AND -> 0x3030; OR -> 0xFCFC; XOR -> 0xCCCC; NOTA a=0x00FF -> 0xFF00. All with carry_out=0.
5. Handshake:
   - start pulsed during RUN with different operands -> ignored; the first result completes unchanged.
   - start held high continuously -> done pulses every 5 cycles with each newly latched operation.
6. rst_n=0 for one edge during RUN idx=2 -> next cycle state IDLE, busy=0, done=0, result=0, carry_out=0, zero=0; no done pulse follows. A new ADD then completes correctly.
